seq_always_stage16_arb_mux: RTL

Parametrised N-channel arbitrating multiplexer with a registered valid/ready output stage. It is the sequential successor of the team's combinational select/case blocks, adding a selectable arbitration mode (fixed priority or round-robin), optional packet locking, and a one-deep output register. It sits in the elaboration test corpus as the reference design for always_ff with asynchronous reset, loop-with-break pickers, and enum state machines.

---
 rtl/seq_always_stage16_arb_mux_pkg.sv | 9 +
 rtl/seq_always_stage16_arb_mux_rr_pick.sv | 34 +++
 rtl/seq_always_stage16_arb_mux.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_always_stage16_arb_mux_pkg.sv
// Shared types for the arbitrating multiplexer: arbitration mode and the
// packet-lock state encoding.
package seq_always_pkg;

  typedef enum {ARB_FIXED, ARB_RR} arb_mode_e;

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;

endpackage

// File: rtl/seq_always_stage16_arb_mux_rr_pick.sv
// Combinational picker: first set bit of the eligible mask, searched upward
// from start+1 (round-robin) or from bit 0 (fixed priority), wrapping.
module seq_always_rr_pick
  import seq_always_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  eligible,
  input  logic [IDX_W-1:0] start,
  input  arb_mode_e        mode,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int base_idx;
  int cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    base_idx    = (mode == ARB_FIXED) ? 0 : (int'(start) + 1) % N_CH;
    for (int off = 0; off < N_CH; off++) begin
      cand = (base_idx + off) % N_CH;
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
        break;
      end
    end
  end

endmodule

// File: rtl/seq_always_stage16_arb_mux.sv
// N-channel arbitrating mux with optional packet locking and a one-deep
// registered valid/ready output stage.
module seq_always_stage16_arb_mux
  import seq_always_pkg::*;
#(
  parameter int        N_CH        = 4,
  parameter int        WIDTH       = 8,
  parameter arb_mode_e ARB_MODE    = ARB_RR,
  parameter int        PACKET_MODE = 1,
  parameter int        IDX_W       = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [IDX_W-1:0]      out_idx,
  input  logic                  out_ready
);

  function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  arb_state_e       state;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] rr_ptr;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             last_p1;
  logic [IDX_W-1:0] idx_p1;

  logic             load_en;
  logic [N_CH-1:0]  eligible;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;
  logic [WIDTH-1:0] grant_data;
  logic             grant_last;

  // Stage p0: eligibility, pick and handshake (out_ready feeds in_ready combinationally)
  assign load_en  = !vld_p1 || out_ready;
  assign eligible = (state == ST_LOCKED) ? (in_valid & onehot(lock_idx)) : in_valid;

  seq_always_rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible    (eligible),
    .start       (rr_ptr),
    .mode        (ARB_MODE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Eligible implies in_valid, so a ready grant is already a handshake.
  assign accept     = rst_n && load_en && grant_valid;
  assign grant_data = in_data[int'(grant_idx) * WIDTH +: WIDTH];
  assign grant_last = in_last[grant_idx];

  always_comb begin
    in_ready = '0;
    if (accept) in_ready = onehot(grant_idx);
  end

  // Stage p1: registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      idx_p1  <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= grant_data;
      last_p1 <= grant_last;
      idx_p1  <= grant_idx;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDX_W'(N_CH - 1);
    end else if (ARB_MODE == ARB_RR && accept) begin
      rr_ptr <= grant_idx;
    end
  end

  // Packet lock: a non-last beat pins the grant until that channel's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lock_idx <= '0;
    end else if (PACKET_MODE != 0 && accept) begin
      case (state)
        ST_IDLE: begin
          if (!grant_last) begin
            state    <= ST_LOCKED;
            lock_idx <= grant_idx;
          end
        end
        ST_LOCKED: begin
          if (grant_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_idx   = idx_p1;

endmodule
